// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive path.
//   - ps2_state_t : receiver FSM state encoding (2 bits)
//   - frame constants (data width, start/stop line levels)
//   - default glitch-filter length and mid-frame timeout
`timescale 1ns/1ps
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   localparam int FILTER_LEN_DEF     = 8;
   localparam int TIMEOUT_CYCLES_DEF = 2500;   // ~200 us at 12.5 MHz

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises the raw PS/2 clock into the clk domain and
// removes glitches. The filtered level only follows the synchronised input
// after FILTER_LEN consecutive cycles of disagreement.
//   clk, reset : system clock, async active-high reset
//   ps2_clk    : raw PS/2 clock (asynchronous)
//   clk_filt   : filtered PS/2 clock level (resets to 1, the idle level)
//   fall       : one-cycle pulse when clk_filt goes 1 -> 0
`timescale 1ns/1ps
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   output logic clk_filt,
   output logic fall
);

   localparam int             CW      = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

   logic          sync1, sync2, filt_prev;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         clk_filt  <= 1'b1;
         filt_prev <= 1'b1;
         cnt       <= '0;
      end else begin
         sync1     <= ps2_clk;
         sync2     <= sync1;
         filt_prev <= clk_filt;
         // Any cycle of agreement restarts the count, so short pulses die here.
         if (sync2 != clk_filt) begin
            if (cnt == CNT_MAX) begin
               clk_filt <= ~clk_filt;
               cnt      <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign fall = filt_prev & ~clk_filt;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver. Deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) into scancode bytes.
// Build option: define PS2_RX_PARITY_EN to drop frames with bad parity;
// otherwise the parity bit is consumed but not checked.
//   clk, reset : system clock, async active-high reset
//   ps2_clk    : raw PS/2 clock (asynchronous)
//   ps2_data   : raw PS/2 data (asynchronous)
//   strobe_out : one-cycle pulse, code_out valid this cycle
//   code_out   : last received byte, held between strobes
//   error      : one-cycle pulse on a dropped frame (stop/parity/timeout)
//   busy       : frame in progress
`timescale 1ns/1ps
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = FILTER_LEN_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       strobe_out,
   output logic [7:0] code_out,
   output logic       error,
   output logic       busy
);

   localparam int            BW       = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CYCLES - 1);

   logic                 fall;
   logic                 data_s1, data_s;
   ps2_state_t           state, state_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [BW-1:0]        bitcnt, bitcnt_n;
   logic [TW-1:0]        tcnt, tcnt_n;
   logic [7:0]           code_n;
   logic                 strobe_n, error_n;
   logic                 frame_ok;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .clk_filt (),
      .fall     (fall)
   );

`ifdef PS2_RX_PARITY_EN
   logic par, par_n;
   assign frame_ok = (data_s == STOP_LEVEL) && odd_parity_ok(shreg, par);
`else
   assign frame_ok = (data_s == STOP_LEVEL);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_s1    <= 1'b1;
         data_s     <= 1'b1;
         state      <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         tcnt       <= '0;
         code_out   <= 8'h00;
         strobe_out <= 1'b0;
         error      <= 1'b0;
`ifdef PS2_RX_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         data_s1    <= ps2_data;
         data_s     <= data_s1;
         state      <= state_n;
         shreg      <= shreg_n;
         bitcnt     <= bitcnt_n;
         tcnt       <= tcnt_n;
         code_out   <= code_n;
         strobe_out <= strobe_n;
         error      <= error_n;
`ifdef PS2_RX_PARITY_EN
         par        <= par_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      bitcnt_n = bitcnt;
      code_n   = code_out;
      strobe_n = 1'b0;
      error_n  = 1'b0;
      tcnt_n   = (state == IDLE) ? '0 : tcnt + 1'b1;
`ifdef PS2_RX_PARITY_EN
      par_n    = par;
`endif
      // A fall beats a coinciding timeout: the bit is consumed and the
      // watchdog restarts.
      if (fall) begin
         tcnt_n = '0;
         case (state)
            IDLE: begin
               // A high data line on a fall is a spurious edge, ignored.
               if (data_s == START_LEVEL) begin
                  state_n  = DATA;
                  bitcnt_n = '0;
               end
            end
            DATA: begin
               shreg_n[bitcnt] = data_s;
               if (bitcnt == BIT_LAST) state_n = PARITY;
               else                    bitcnt_n = bitcnt + 1'b1;
            end
            PARITY: begin
`ifdef PS2_RX_PARITY_EN
               par_n   = data_s;
`endif
               state_n = STOP;
            end
            STOP: begin
               if (frame_ok) begin
                  code_n   = shreg;
                  strobe_n = 1'b1;
               end else begin
                  error_n  = 1'b1;
               end
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE && tcnt == T_MAX) begin
         state_n = IDLE;
         error_n = 1'b1;
         tcnt_n  = '0;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 keyboard receiver. Deserialises the device-driven ps2_clk/ps2_data pair into 8-bit scancode bytes.
- Presents each byte as a one-cycle strobe plus data.
- Sits directly upstream of scancode_convert: strobe_out drives its strobe_in, code_out drives its code_in.

Parameters:
- FILTER_LEN, 8: consecutive stable samples of synchronised ps2_clk required before the filtered level changes.
- TIMEOUT_CYCLES, 2500: clk cycles without a filtered falling edge mid-frame before the frame is aborted (about 200 us at 12.5 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock from connector; asynchronous to clk
- ps2_data  in  1  raw PS/2 data from connector; asynchronous to clk
- strobe_out  out  1  one-cycle pulse; code_out valid this cycle
- code_out  out  8  received byte; holds last value between strobes
- error  out  1  one-cycle pulse on a dropped frame (bad stop, bad parity, timeout)
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, active-high): strobe_out=0, code_out=8'h00, error=0, busy=0.
  - Also clears: state=IDLE, shift register, bit counter, timeout counter, filter counter.
  - Filtered clock level resets to 1; synchronisers reset to 1.
- Synchronisation:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - ps2_data is sampled only from the synchronised copy.
- Clock filter:
  - Counter increments while the synchronised ps2_clk differs from the filtered level, and clears when they agree.
  - When it reaches FILTER_LEN-1, the filtered level toggles and the counter clears.
  - Pulses shorter than FILTER_LEN cycles never reach the FSM.
- Edge: fall = filtered level was 1 last cycle and is 0 now. Every action below happens only on a fall cycle.
- FSM, one bit consumed per fall, 11-bit frame:
  - IDLE: data==0 -> DATA with bit counter=0. data==1 -> stay IDLE (spurious edge, no error).
  - DATA: shift data into bit[counter], LSB first. After the 8th bit -> PARITY.
  - PARITY: latch parity bit -> STOP.
  - STOP: data==1 and parity OK -> code_out<=byte, strobe_out=1 for one cycle. Otherwise error=1 for one cycle. Either way -> IDLE.
- Parity is odd: XOR of 8 data bits and parity bit must equal 1.
- Latency: strobe_out/error assert on the clk cycle after the fall that samples the stop bit; the pulse lasts exactly one cycle.
- Timeout:
  - Counter clears on every fall and while in IDLE; increments otherwise.
  - At TIMEOUT_CYCLES-1 in any non-IDLE state -> IDLE with error=1 for one cycle; partial byte discarded.
- Priority if timeout and fall coincide: fall wins, counter clears.
- strobe_out and error are never high in the same cycle.
- Reset asserted mid-frame aborts the frame; no strobe or error is generated for it.
- No backpressure: the consumer must accept strobe_out in its asserted cycle. PS/2 frame spacing guarantees at least 500 clk cycles between strobes at 12.5 MHz.

Optional Feature:
- Macro: PS2_RX_PARITY_EN
- Defined: parity is checked as above; a bad parity drops the frame and pulses error.
- Undefined: the parity bit is sampled but ignored; only stop-bit and timeout faults pulse error.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP, 2 bits).
  - Frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1.
  - Default FILTER_LEN and TIMEOUT_CYCLES.
- One natural sub-module, ps2_clk_filter:
  - Contains the synchroniser and glitch filter; parameter FILTER_LEN.
  - Outputs the filtered level and a one-cycle fall pulse.
  - Reusable for a future PS/2 transmitter.

Test Plan:
- Frame 8'h1C (start 0, data LSB first, parity 0, stop 1; 40 us half-periods, clk 80 ns) -> one strobe_out, code_out=8'h1C, error never high.
- Sequence 8'h1C, 8'hF0 (parity 1), 8'h1C -> exactly three strobes with codes 1C, F0, 1C. Feeding these into scancode_convert yields one keycode strobe.
- 8'h32 sent with parity bit 1 -> no strobe, one error pulse, code_out unchanged. With PS2_RX_PARITY_EN undefined -> strobe, code_out=8'h32, no error.
- Stop bit driven 0 on 8'h5A -> error pulse, no strobe. Next valid frame 8'h12 -> strobe, code_out=8'h12.
- Five bits, then clock idles 300 us -> error pulse after TIMEOUT_CYCLES, busy falls. A following 8'h14 frame decodes correctly.
- 200 ns ps2_clk glitches during IDLE and mid-bit -> no FSM advance. Reset pulsed mid-frame -> outputs at reset values, no error pulse. Next frame 8'h23 decodes.
